dpram_loader: RTL and testbench

- Byte-stream program loader on the host side of the 4K x 16 dual-port RAM. Drives port 2 (addr2/din2/we2).
- Accepts bytes over a valid/ready handshake, takes a 16-bit word count, assembles big-endian 16-bit words, writes them to consecutive RAM addresses from a base address.
- The CPU keeps port 1; it is held off by software until done is high.

---
 rtl/dpram_loader_if.sv | 24 ++
 rtl/dpram_loader.sv | 179 +++++++++++++++++
 tb/tb_dpram_loader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/dpram_loader_if.sv
// Byte-stream and RAM port-2 signal bundle for dpram_loader.
// A byte moves on a rising clock edge where byte_valid and byte_ready are both 1;
// byte_ready never depends on byte_valid, and the source holds byte_in while byte_valid waits.
interface dpram_loader_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
);
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic [ADDR_W-1:0] addr2;
   logic [DATA_W-1:0] din2;
   logic              we2;

   modport master (
      output byte_in, byte_valid,
      input  byte_ready, addr2, din2, we2
   );

   modport slave (
      input  byte_in, byte_valid,
      output byte_ready, addr2, din2, we2
   );
endinterface

// File: rtl/dpram_loader.sv
// Loads a length-prefixed big-endian byte stream into RAM port 2 from BASE_ADDR.
// Optional trailing checksum byte enabled by macro DPRAM_LOADER_CHECKSUM_EN.
module dpram_loader #(
   parameter int                ADDR_W    = 12,
   parameter int                DATA_W    = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   dpram_loader_if.slave  bus,
   output logic           busy,
   output logic           done,
   output logic           error,
   output logic [2:0]     o_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DAT_HI = 3'd3,
      S_DAT_LO = 3'd4,
      S_WR     = 3'd5,
      S_CHK    = 3'd6,
      S_FIN    = 3'd7
   } state_t;

   localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

   state_t            r_state;
   state_t            w_state_next;
   logic [15:0]       r_count;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_din;
   logic              r_busy;
   logic              r_done;
   logic              r_error;
   logic              w_ready;
   logic              w_accept;
   logic [15:0]       w_len;
   logic              w_oversize;
`ifdef DPRAM_LOADER_CHECKSUM_EN
   logic [7:0]        r_sum;
`endif

   // Full length as it will look once the low byte lands this cycle.
   assign w_len      = {r_count[15:8], bus.byte_in};
   assign w_oversize = {1'b0, w_len} > MAX_WORDS;
   assign w_accept   = w_ready & bus.byte_valid;

   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      case (r_state)
         S_IDLE: if (start) w_state_next = S_LEN_HI;
         S_LEN_HI: begin
            w_ready = 1'b1;
            if (bus.byte_valid) w_state_next = S_LEN_LO;
         end
         S_LEN_LO: begin
            w_ready = 1'b1;
            if (bus.byte_valid) begin
               if (w_len == 16'd0 || w_oversize) w_state_next = S_FIN;
               else                              w_state_next = S_DAT_HI;
            end
         end
         S_DAT_HI: begin
            w_ready = 1'b1;
            if (bus.byte_valid) w_state_next = S_DAT_LO;
         end
         S_DAT_LO: begin
            w_ready = 1'b1;
            if (bus.byte_valid) w_state_next = S_WR;
         end
         S_WR: begin
            if (r_count == 16'd1) begin
`ifdef DPRAM_LOADER_CHECKSUM_EN
               w_state_next = S_CHK;
`else
               w_state_next = S_FIN;
`endif
            end else begin
               w_state_next = S_DAT_HI;
            end
         end
         S_CHK: begin
`ifdef DPRAM_LOADER_CHECKSUM_EN
            w_ready = 1'b1;
            if (bus.byte_valid) w_state_next = S_FIN;
`else
            w_state_next = S_IDLE;
`endif
         end
         S_FIN:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_count <= 16'd0;
         r_addr  <= BASE_ADDR;
         r_din   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
`ifdef DPRAM_LOADER_CHECKSUM_EN
         r_sum   <= 8'd0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_done  <= 1'b0;
                  r_error <= 1'b0;
                  r_busy  <= 1'b1;
                  r_addr  <= BASE_ADDR;
`ifdef DPRAM_LOADER_CHECKSUM_EN
                  r_sum   <= 8'd0;
`endif
               end
            end
            S_LEN_HI: if (w_accept) r_count[15:8] <= bus.byte_in;
            S_LEN_LO: begin
               if (w_accept) begin
                  r_count[7:0] <= bus.byte_in;
                  if (w_oversize) r_error <= 1'b1;
               end
            end
            S_DAT_HI: begin
               if (w_accept) begin
                  r_din[DATA_W-1 -: 8] <= bus.byte_in;
`ifdef DPRAM_LOADER_CHECKSUM_EN
                  r_sum <= r_sum + bus.byte_in;
`endif
               end
            end
            S_DAT_LO: begin
               if (w_accept) begin
                  r_din[7:0] <= bus.byte_in;
`ifdef DPRAM_LOADER_CHECKSUM_EN
                  r_sum <= r_sum + bus.byte_in;
`endif
               end
            end
            S_WR: begin
               r_addr  <= r_addr + ADDR_W'(1);
               r_count <= r_count - 16'd1;
            end
`ifdef DPRAM_LOADER_CHECKSUM_EN
            S_CHK: begin
               if (w_accept && (r_sum + bus.byte_in) != 8'd0) r_error <= 1'b1;
            end
`endif
            S_FIN: begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.byte_ready = w_ready;
   assign bus.we2        = (r_state == S_WR);
   assign bus.addr2      = r_addr;
   assign bus.din2       = r_din;
   assign busy           = r_busy;
   assign done           = r_done;
   assign error          = r_error;
   assign o_state        = r_state;

endmodule

// File: tb/tb_dpram_loader.sv
// Directed bench for dpram_loader: two instances (base 000 and FFF) share one byte stream.
module tb_dpram_loader;

   logic        clock;
   logic        reset;
   logic        start;
   logic [7:0]  s_byte;
   logic        s_valid;
   logic        busy0, done0, err0;
   logic        busy1, done1, err1;
   logic [2:0]  st0, st1;

   int n_vec;
   int n_err;

   logic [27:0] exp_q0[$];
   logic [27:0] exp_q1[$];

   dpram_loader_if #(.ADDR_W(12), .DATA_W(16)) bus0 ();
   dpram_loader_if #(.ADDR_W(12), .DATA_W(16)) bus1 ();

   assign bus0.byte_in    = s_byte;
   assign bus0.byte_valid = s_valid;
   assign bus1.byte_in    = s_byte;
   assign bus1.byte_valid = s_valid;

   dpram_loader #(.ADDR_W(12), .DATA_W(16), .BASE_ADDR(12'h000)) dut0 (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .bus     (bus0),
      .busy    (busy0),
      .done    (done0),
      .error   (err0),
      .o_state (st0)
   );

   dpram_loader #(.ADDR_W(12), .DATA_W(16), .BASE_ADDR(12'hFFF)) dut1 (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .bus     (bus1),
      .busy    (busy1),
      .done    (done1),
      .error   (err1),
      .o_state (st1)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // scoreboard: every we2 pulse must match the head of the expected queue
   always @(negedge clock) begin
      if (bus0.we2) begin
         if (exp_q0.size() == 0) check("we2_unexpected0", exp_q0.size(), 1);
         else check("write0", {bus0.addr2, bus0.din2}, exp_q0.pop_front());
      end
      if (bus1.we2) begin
         if (exp_q1.size() == 0) check("we2_unexpected1", exp_q1.size(), 1);
         else check("write1", {bus1.addr2, bus1.din2}, exp_q1.pop_front());
      end
   end

   // driver tasks
   task automatic send(input logic [7:0] b, input bit thr);
      int t;
      t = 0;
      if (thr) begin
         @(negedge clock);
         s_valid = 1'b0;
      end
      @(negedge clock);
      s_byte  = b;
      s_valid = 1'b1;
      while (!bus0.byte_ready && t < 50) begin
         @(negedge clock);
         t++;
      end
      if (t >= 50) check("ready_timeout", t, 0);
      if (thr) check("ready_wait", t, 0);
      @(posedge clock);
   endtask

   task automatic src_idle();
      @(negedge clock);
      s_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic run_load(input logic [15:0] len, input logic [31:0] data,
                           input bit thr, input bit bad_sum, input bit exp_err);
      int          n;
      int          t;
      logic [7:0]  sum;
      logic [15:0] w;
      logic [11:0] a;
      n   = (len == 16'd0 || len > 16'd4096) ? 0 : int'(len);
      sum = 8'd0;
      pulse_start();
      check("busy_after_start", busy0, 1);
      check("done_cleared", done0, 0);
      check("error_cleared", err0, 0);
      send(len[15:8], thr);
      send(len[7:0], thr);
      for (int i = 0; i < n; i++) begin
         w = data[31-16*i -: 16];
         a = 12'(i);
         exp_q0.push_back({a, w});
         a = 12'hFFF + 12'(i);
         exp_q1.push_back({a, w});
         send(w[15:8], thr);
         send(w[7:0], thr);
         sum = sum + w[15:8] + w[7:0];
      end
`ifdef DPRAM_LOADER_CHECKSUM_EN
      if (n > 0) begin
         w[7:0] = 8'd0 - sum + (bad_sum ? 8'd1 : 8'd0);
         send(w[7:0], thr);
      end
`else
      if (bad_sum) check("bad_sum_unsupported", 32'(bad_sum), 0);
`endif
      src_idle();
      t = 0;
      while (!done0 && t < 100) begin
         @(negedge clock);
         t++;
      end
      if (t >= 100) check("done_timeout", t, 0);
      check("busy_end", busy0, 0);
      check("done_end", done0, 1);
      check("error_end", err0, 32'(exp_err));
      check("done_end1", done1, 1);
      check("error_end1", err1, 32'(exp_err));
      check("pending_writes0", exp_q0.size(), 0);
      check("pending_writes1", exp_q1.size(), 0);
      repeat (2) @(negedge clock);
      check("done_held", done0, 1);
      check("busy_idle", busy1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec   = 0;
      n_err   = 0;
      reset   = 1'b1;
      start   = 1'b0;
      s_byte  = 8'h00;
      s_valid = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_ready", bus0.byte_ready, 0);
      check("rst_addr0", bus0.addr2, 12'h000);
      check("rst_addr1", bus1.addr2, 12'hFFF);
      check("rst_din", bus0.din2, 16'h0000);
      check("rst_we2", bus0.we2, 0);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_error", err0, 0);
      reset = 1'b0;

      // basic, throttled, zero, oversize, wrap-style data
      run_load(16'h0002, 32'h1234ABCD, 1'b0, 1'b0, 1'b0);
      run_load(16'h0002, 32'h1234ABCD, 1'b1, 1'b0, 1'b0);
      run_load(16'h0000, 32'h00000000, 1'b0, 1'b0, 1'b0);
      run_load(16'h1001, 32'h00000000, 1'b0, 1'b0, 1'b1);
      run_load(16'h0002, 32'h00010002, 1'b0, 1'b0, 1'b0);

      // reset one cycle after the first word's write
      pulse_start();
      send(8'h00, 1'b0);
      send(8'h02, 1'b0);
      exp_q0.push_back({12'h000, 16'h1234});
      exp_q1.push_back({12'hFFF, 16'h1234});
      send(8'h12, 1'b0);
      send(8'h34, 1'b0);
      src_idle();
      check("we2_in_wr", bus0.we2, 1);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("mid_rst_we2", bus0.we2, 0);
      check("mid_rst_busy", busy0, 0);
      check("mid_rst_done", done0, 0);
      check("mid_rst_addr1", bus1.addr2, 12'hFFF);
      check("mid_rst_ready", bus0.byte_ready, 0);
      reset = 1'b0;

      run_load(16'h0001, 32'h5A5A0000, 1'b0, 1'b0, 1'b0);
`ifdef DPRAM_LOADER_CHECKSUM_EN
      run_load(16'h0001, 32'h12340000, 1'b0, 1'b1, 1'b1);
      run_load(16'h0001, 32'h12340000, 1'b1, 1'b0, 1'b0);
`endif

      repeat (3) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
